mm_stream_requester: RTL and testbench

//  Requester for the mm_iddmm_top word-serial Montgomery multiply interface. Buffers one x/y operand pair
//  (N words of K bits each) from an upstream loader, issues mm_start, then streams x/y to the multiplier.

---
 rtl/mm_stream_pkg.sv | 21 ++
 rtl/mm_word_buf.sv | 23 ++
 rtl/mm_stream_requester.sv | 177 +++++++++++++++++
 tb/tb_mm_stream_requester.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mm_stream_pkg.sv
// Shared types for the mm_iddmm_top word-serial requester: FSM states, multiply type, index width helper.
package mm_stream_pkg;

  typedef enum logic [2:0] {
    LOAD,
    START,
    GAP,
    SEND,
    WAIT,
    RECV,
    DRAIN
  } mm_state_e;

  typedef logic [1:0] mm_type_t;

  // Width of a counter addressing n entries; never below 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_word_buf.sv
// N x K register file with one synchronous write port and one asynchronous read port.
module mm_word_buf #(
  parameter int K  = 128,
  parameter int N  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [K-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [K-1:0]  rdata
);

  logic [K-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mm_stream_requester.sv
// Buffers one x/y operand pair, streams it to mm_iddmm_top, captures the result burst and replays it downstream.
// Optional watchdog on the result wait is built only when MM_TIMEOUT_EN is defined.
module mm_stream_requester
  import mm_stream_pkg::*;
#(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int TMO_CYC = 4096
) (
  input  logic      clk,
  input  logic      rst_n,
  input  mm_type_t  op_type,
  input  logic [K-1:0] op_x,
  input  logic [K-1:0] op_y,
  input  logic      op_valid,
  output logic      op_ready,
  output mm_type_t  mm_type,
  output logic      mm_start,
  output logic [K-1:0] mm_x,
  output logic [K-1:0] mm_y,
  output logic      mm_x_valid,
  output logic      mm_y_valid,
  input  logic [K-1:0] mm_result,
  input  logic      mm_valid,
  output logic [K-1:0] res_word,
  output logic      res_valid,
  output logic      res_last,
  input  logic      res_ready,
  output logic      busy,
  output logic      err_timeout,
  output mm_state_e state_dbg
);

  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  mm_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  mm_type_t         type_q, type_d;
  logic [K-1:0]     x_rd, y_rd, r_rd;
  logic             op_we, res_we, tmo_hit;

  // Handshakes: a word moves on a rising edge where valid and ready are both high; op_ready and
  // res_valid depend on state only. The mm_result burst has no ready and is captured unconditionally.
  assign op_we  = (state_q == LOAD) && op_valid;
  assign res_we = ((state_q == WAIT) && mm_valid) || (state_q == RECV);

  mm_word_buf #(.K(K), .N(N), .AW(IDX_W)) u_xbuf (
    .clk(clk), .we(op_we), .waddr(idx_q), .wdata(op_x), .raddr(idx_q), .rdata(x_rd)
  );
  mm_word_buf #(.K(K), .N(N), .AW(IDX_W)) u_ybuf (
    .clk(clk), .we(op_we), .waddr(idx_q), .wdata(op_y), .raddr(idx_q), .rdata(y_rd)
  );
  mm_word_buf #(.K(K), .N(N), .AW(IDX_W)) u_rbuf (
    .clk(clk), .we(res_we), .waddr(idx_q), .wdata(mm_result), .raddr(idx_q), .rdata(r_rd)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    type_d     = type_q;
    op_ready   = 1'b0;
    busy       = 1'b1;
    mm_start   = 1'b0;
    mm_x_valid = 1'b0;
    res_valid  = 1'b0;
    res_last   = 1'b0;
    unique case (state_q)
      LOAD: begin
        op_ready = 1'b1;
        busy     = 1'b0;
        if (op_valid) begin
          if (idx_q == '0) type_d = op_type;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      START: begin
        mm_start = 1'b1;
        state_d  = GAP;
      end
      GAP: state_d = SEND;
      SEND: begin
        mm_x_valid = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = WAIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      WAIT: begin
        if (mm_valid) begin
          idx_d   = IDX_W'(1);
          state_d = RECV;
        end else if (tmo_hit) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      RECV: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        res_valid = 1'b1;
        res_last  = (idx_q == IDX_LAST);
        if (res_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      type_q  <= type_d;
    end
  end

  // Data outputs are zeroed outside their phases so an aborted operation leaves mm_* quiet.
  assign mm_type    = (state_q inside {START, GAP, SEND, WAIT, RECV}) ? type_q : '0;
  assign mm_x       = (state_q == SEND) ? x_rd : '0;
  assign mm_y       = (state_q == SEND) ? y_rd : '0;
  assign mm_y_valid = mm_x_valid;
  assign res_word   = (state_q == DRAIN) ? r_rd : '0;
  assign state_dbg  = state_q;

`ifdef MM_TIMEOUT_EN
  localparam int CNT_W = idx_width(TMO_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;

  assign tmo_hit = (tmo_cnt_q == CNT_W'(TMO_CYC - 1));

  // Counter sits at zero outside WAIT, so every entry into WAIT starts a fresh budget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q     <= (state_q == WAIT) && !mm_valid && tmo_hit;
      tmo_cnt_q <= (state_q == WAIT) ? tmo_cnt_q + CNT_W'(1) : '0;
    end
  end

  assign err_timeout = err_q;
`else
  assign tmo_hit     = 1'b0;
  // Always false; TMO_CYC only has meaning when the watchdog is built.
  assign err_timeout = (TMO_CYC < 0);
`endif

endmodule

// File: tb/tb_mm_stream_requester.sv
// Self-checking bench for mm_stream_requester: operation table plus scoreboard queues for x/y/result words.
module tb_mm_stream_requester;
  import mm_stream_pkg::*;

  localparam int K   = 128;
  localparam int N   = 32;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  mm_type_t     op_type;
  logic [K-1:0] op_x, op_y;
  logic         op_valid;
  logic         op_ready;
  mm_type_t     mm_type;
  logic         mm_start;
  logic [K-1:0] mm_x, mm_y;
  logic         mm_x_valid, mm_y_valid;
  logic [K-1:0] mm_result;
  logic         mm_valid;
  logic [K-1:0] res_word;
  logic         res_valid, res_last, res_ready;
  logic         busy, err_timeout;
  mm_state_e    state_dbg;

  mm_stream_requester #(.K(K), .N(N), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .op_type(op_type), .op_x(op_x), .op_y(op_y),
    .op_valid(op_valid), .op_ready(op_ready), .mm_type(mm_type), .mm_start(mm_start),
    .mm_x(mm_x), .mm_y(mm_y), .mm_x_valid(mm_x_valid), .mm_y_valid(mm_y_valid),
    .mm_result(mm_result), .mm_valid(mm_valid), .res_word(res_word), .res_valid(res_valid),
    .res_last(res_last), .res_ready(res_ready), .busy(busy), .err_timeout(err_timeout),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [K-1:0] x_exp_q[$];
  logic [K-1:0] y_exp_q[$];
  logic [K-1:0] res_exp_q[$];

  typedef struct {
    mm_type_t typ;        // inputs
    int       kind;       // 0: operand value 1, 1: random words
    bit       echo;       // multiplier returns word index instead of a function of x/y
    int       ready_mode; // 0: always, 1: 1010 with a 20-cycle hold, 2: random
    int       lat;        // WAIT cycles before the result burst
    bit       spurious;   // stray mm_valid/op_valid outside their phases
    bit       rst_mid;    // reset pulse at SEND idx=10
    bit       no_resp;    // multiplier never answers
    mm_type_t exp_type;   // expected outputs
    bit       exp_result; // a result burst is expected downstream
  } op_vec_t;

  task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [K-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stand-in multiplier function (not a real Montgomery product; only replay fidelity matters here).
  function automatic logic [K-1:0] mult_model(input logic [K-1:0] x, input logic [K-1:0] y,
                                              input mm_type_t t, input int i, input bit echo);
    if (echo) return K'(i);
    return (x ^ {y[K-2:0], y[K-1]}) + K'(t) + K'(i);
  endfunction

  function automatic op_vec_t mk(input mm_type_t typ, input int kind, input bit echo, input int rm,
                                 input int lat, input bit spur, input bit rst_mid, input bit no_resp);
    op_vec_t v;
    v.typ = typ; v.kind = kind; v.echo = echo; v.ready_mode = rm; v.lat = lat;
    v.spurious = spur; v.rst_mid = rst_mid; v.no_resp = no_resp;
    v.exp_type = typ; v.exp_result = !(rst_mid || no_resp);
    return v;
  endfunction

  task automatic run_op(input op_vec_t v);
    logic [K-1:0] ox[N], oy[N], mx[N], my[N], prev_word;
    mm_type_t mt;
    int got, cyc;
    bit rdy, prev_stall;
    for (int i = 0; i < N; i++) begin
      ox[i] = (v.kind == 0) ? ((i == 0) ? K'(1) : '0) : rand_word();
      oy[i] = (v.kind == 0) ? ((i == 0) ? K'(1) : '0) : rand_word();
      x_exp_q.push_back(ox[i]);
      y_exp_q.push_back(oy[i]);
      if (v.exp_result) res_exp_q.push_back(mult_model(ox[i], oy[i], v.typ, i, v.echo));
    end
    // Load: type is presented inverted after word 0 to show only the first word's type is kept.
    for (int i = 0; i < N; i++) begin
      op_valid = 1'b1; op_x = ox[i]; op_y = oy[i];
      op_type  = (i == 0) ? v.typ : ~v.typ;
      mm_valid = v.spurious; mm_result = rand_word();
      if (i == 0 || i == N - 1) check("op_ready_load", K'(op_ready), K'(1));
      @(negedge clk);
    end
    op_valid = 1'b0; mm_valid = 1'b0;
    check("start_pulse", K'(mm_start), K'(1));
    check("busy_start", K'(busy), K'(1));
    check("op_ready_start", K'(op_ready), K'(0));
    check("mm_type_start", K'(mm_type), K'(v.exp_type));
    @(negedge clk);
    check("gap_start", K'(mm_start), K'(0));
    check("gap_valid", K'(mm_x_valid), K'(0));
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      mm_valid = v.spurious; mm_result = rand_word();
      check("x_valid", K'(mm_x_valid), K'(1));
      check("y_valid", K'(mm_y_valid), K'(1));
      if (x_exp_q.size() > 0) check("mm_x", mm_x, x_exp_q.pop_front());
      if (y_exp_q.size() > 0) check("mm_y", mm_y, y_exp_q.pop_front());
      mx[i] = mm_x; my[i] = mm_y;
      if (i == 0) mt = mm_type;
      if (v.rst_mid && i == 10) begin
        rst_n = 1'b0; mm_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", K'(busy), K'(0));
        check("rst_op_ready", K'(op_ready), K'(1));
        check("rst_x_valid", K'(mm_x_valid), K'(0));
        check("rst_mm_x", mm_x, '0);
        x_exp_q.delete(); y_exp_q.delete();
        return;
      end
      @(negedge clk);
    end
    mm_valid = 1'b0;
    check("send_len", K'(mm_x_valid), K'(0));
    if (v.no_resp) begin
      for (int j = 0; j < TMO; j++) begin
        check("tmo_early", K'(err_timeout), K'(0));
        @(negedge clk);
      end
      check("tmo_pulse", K'(err_timeout), K'(1));
      check("tmo_state", K'(state_dbg), K'(LOAD));
      check("tmo_op_ready", K'(op_ready), K'(1));
      @(negedge clk);
      check("tmo_pulse_end", K'(err_timeout), K'(0));
      return;
    end
    for (int j = 0; j < v.lat; j++) begin
      op_valid = v.spurious; op_x = rand_word(); op_y = rand_word();
      @(negedge clk);
    end
    op_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      mm_valid = 1'b1;
      mm_result = mult_model(mx[i], my[i], mt, i, v.echo);
      if (i == N - 1) begin
        check("res_early", K'(res_valid), K'(0));
        check("mm_type_recv", K'(mm_type), K'(v.exp_type));
      end
      @(negedge clk);
    end
    mm_valid = v.spurious; mm_result = rand_word();
    check("res_latency", K'(res_valid), K'(1));
    got = 0; cyc = 0; prev_stall = 1'b0; prev_word = '0;
    while (got < N && cyc < 400) begin
      case (v.ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc >= 10 && cyc < 30) ? 1'b0 : ((cyc % 2) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      res_ready = rdy;
      check("drain_valid", K'(res_valid), K'(1));
      if (prev_stall) check("stall_hold", res_word, prev_word);
      if (res_valid && rdy) begin
        if (res_exp_q.size() > 0) check("res_word", res_word, res_exp_q.pop_front());
        check("res_last", K'(res_last), K'(got == N - 1));
        got++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_word  = res_word;
      end
      cyc++;
      @(negedge clk);
    end
    res_ready = 1'b0; mm_valid = 1'b0;
    check("drain_count", K'(got), K'(N));
    check("op_ready_return", K'(op_ready), K'(1));
    check("busy_return", K'(busy), K'(0));
    check("res_valid_drop", K'(res_valid), K'(0));
    check("no_err", K'(err_timeout), K'(0));
  endtask

  initial begin
    op_vec_t vecs[$];
    rst_n = 1'b0; op_type = '0; op_x = '0; op_y = '0; op_valid = 1'b0;
    mm_result = '0; mm_valid = 1'b0; res_ready = 1'b0;
    vecs.push_back(mk(2'd0, 0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(2'd0, 1, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(2'd1, 1, 1'b0, 2, 1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(2'd2, 1, 1'b0, 1, 3, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(2'd3, 1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(2'd1, 1, 1'b0, 2, 4, 1'b1, 1'b0, 1'b0));
`ifdef MM_TIMEOUT_EN
    vecs.push_back(mk(2'd2, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(2'd0, 1, 1'b1, 1, 2, 1'b0, 1'b0, 1'b0));
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_op_ready", K'(op_ready), K'(1));
    check("reset_busy", K'(busy), K'(0));
    check("reset_start", K'(mm_start), K'(0));
    check("reset_x_valid", K'(mm_x_valid), K'(0));
    check("reset_res_valid", K'(res_valid), K'(0));
    check("reset_mm_type", K'(mm_type), K'(0));
    check("reset_err", K'(err_timeout), K'(0));
    check("reset_state", K'(state_dbg), K'(LOAD));
    foreach (vecs[i]) run_op(vecs[i]);
    check("res_queue_empty", K'(res_exp_q.size()), K'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench timeout");
  end

endmodule
